router_pkt_tx: RTL and testbench

//  Packet source for the router input port: the transmit end feeding data_in/pkt_valid into the router.

---
 rtl/router_pkg.sv | 23 ++
 rtl/router_tx_buf.sv | 22 ++
 rtl/router_pkt_tx.sv | 164 ++++++++++++++++
 tb/tb_router_pkt_tx.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared types and widths for the router transmit slice.
package router_pkg;
  localparam int ADDR_W = 2;
  localparam int LEN_W  = 6;
  localparam int DATA_W = 8;

  localparam logic [ADDR_W-1:0] ADDR_ILLEGAL = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_HEADER   = 3'd2,
    ST_PAYLOAD  = 3'd3,
    ST_PARITY   = 3'd4,
    ST_WAIT_ERR = 3'd5,
    ST_DONE     = 3'd6
  } state_t;

  function automatic logic cfg_legal(input logic [ADDR_W-1:0] addr,
                                     input logic [LEN_W-1:0]  len);
    return (addr != ADDR_ILLEGAL) && (len != '0);
  endfunction
endpackage

// File: rtl/router_tx_buf.sv
// Payload buffer: one synchronous write port, one combinational read port.
module router_tx_buf
  import router_pkg::*;
#(
  parameter int DEPTH = 63
) (
  input  logic              clk,
  input  logic              we,
  input  logic [LEN_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [LEN_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we && (int'(waddr) < DEPTH)) mem_q[waddr] <= wdata;
  end

  // Out-of-range reads return zero rather than aliasing.
  assign rdata = (int'(raddr) < DEPTH) ? mem_q[raddr] : '0;
endmodule

// File: rtl/router_pkt_tx.sv
// Router input-port packet source: buffers a payload, then sends header,
// payload and XOR parity under busy back-pressure, watching err afterwards.
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int ERR_WIN = 8,
  parameter int MAX_LEN = 63
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] dest_addr,
  input  logic [LEN_W-1:0]  pay_len,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              busy,
  input  logic              err,
  output logic [DATA_W-1:0] data_out,
  output logic              pkt_valid,
  output logic              idle,
  output logic              cfg_err,
  output logic              tx_done,
  output logic              tx_err
);
  localparam int WCNT_W = (ERR_WIN > 1) ? $clog2(ERR_WIN) : 1;

  state_t              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    idx_q;
  logic [WCNT_W-1:0]   wcnt_q;
  logic [DATA_W-1:0]   parity_q;
  logic                flag_q;
  logic [DATA_W-1:0]   data_out_q;
  logic                pkt_valid_q, in_ready_q, idle_q, cfg_err_q, tx_done_q, tx_err_q;

  logic                buf_we;
  logic [LEN_W-1:0]    raddr_d;
  logic [DATA_W-1:0]   rdata;
  logic [DATA_W-1:0]   header;

  assign header = {len_q, addr_q};
  assign buf_we = (state_q == ST_LOAD) && in_valid && in_ready_q;

  // Read ahead one slot so the next payload byte can be registered on advance.
  always_comb begin
    raddr_d = '0;
    if (state_q == ST_PAYLOAD) raddr_d = idx_q + LEN_W'(1);
  end

  router_tx_buf #(.DEPTH(MAX_LEN)) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (idx_q),
    .wdata (in_data),
    .raddr (raddr_d),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      wcnt_q      <= '0;
      parity_q    <= '0;
      flag_q      <= 1'b0;
      data_out_q  <= '0;
      pkt_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      idle_q      <= 1'b1;
      cfg_err_q   <= 1'b0;
      tx_done_q   <= 1'b0;
      tx_err_q    <= 1'b0;
    end else begin
      cfg_err_q <= 1'b0;
      tx_done_q <= 1'b0;
      tx_err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (cfg_legal(dest_addr, pay_len)) begin
              addr_q     <= dest_addr;
              len_q      <= pay_len;
              idx_q      <= '0;
              flag_q     <= 1'b0;
              in_ready_q <= 1'b1;
              idle_q     <= 1'b0;
              state_q    <= ST_LOAD;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (in_valid && in_ready_q) begin
            if (idx_q == len_q - LEN_W'(1)) begin
              idx_q       <= '0;
              in_ready_q  <= 1'b0;
              data_out_q  <= header;
              pkt_valid_q <= 1'b1;
              parity_q    <= header;
              state_q     <= ST_HEADER;
            end else begin
              idx_q <= idx_q + LEN_W'(1);
            end
          end
        end
        ST_HEADER: begin
          if (!busy) begin
            data_out_q <= rdata;
            state_q    <= ST_PAYLOAD;
          end
        end
        // data_out_q holds buf[idx] here, so it feeds the parity directly.
        ST_PAYLOAD: begin
          if (!busy) begin
            parity_q <= parity_q ^ data_out_q;
            if (idx_q == len_q - LEN_W'(1)) begin
              data_out_q  <= parity_q ^ data_out_q;
              pkt_valid_q <= 1'b0;
              state_q     <= ST_PARITY;
            end else begin
              idx_q      <= idx_q + LEN_W'(1);
              data_out_q <= rdata;
            end
          end
        end
        ST_PARITY: begin
          if (!busy) begin
            data_out_q <= '0;
            wcnt_q     <= '0;
            state_q    <= ST_WAIT_ERR;
          end
        end
        ST_WAIT_ERR: begin
          flag_q <= flag_q | err;
          if (wcnt_q == WCNT_W'(ERR_WIN - 1)) begin
            tx_done_q <= 1'b1;
            tx_err_q  <= flag_q | err;
            state_q   <= ST_DONE;
          end else begin
            wcnt_q <= wcnt_q + WCNT_W'(1);
          end
        end
        ST_DONE: begin
          idle_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign data_out  = data_out_q;
  assign pkt_valid = pkt_valid_q;
  assign in_ready  = in_ready_q;
  assign idle      = idle_q;
  assign cfg_err   = cfg_err_q;
  assign tx_done   = tx_done_q;
  assign tx_err    = tx_err_q;
endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx with a wire-byte scoreboard.
module tb_router_pkt_tx;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [1:0] dest_addr = '0;
  logic [5:0] pay_len = '0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       busy = 1'b0;
  logic       err = 1'b0;
  logic [7:0] data_out;
  logic       pkt_valid, idle, cfg_err, tx_done, tx_err;

  router_pkt_tx #(.ERR_WIN(8), .MAX_LEN(63)) dut (
    .clk(clk), .rst(rst), .start(start), .dest_addr(dest_addr), .pay_len(pay_len),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .busy(busy), .err(err),
    .data_out(data_out), .pkt_valid(pkt_valid), .idle(idle), .cfg_err(cfg_err),
    .tx_done(tx_done), .tx_err(tx_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       pv;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         failures = 0;
  logic       last_pv = 1'b0;
  logic       par_hold = 1'b0;
  int         hold22 = 0;
  logic [7:0] pay [64];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare the byte currently on the wire; it leaves only at an edge with busy low.
  task automatic mon();
    logic par;
    par = !pkt_valid && (last_pv || par_hold);
    if (pkt_valid || par) begin
      if (sb.size() == 0) begin
        chk("wire_unexpected", {23'd0, pkt_valid, data_out}, 32'hFFFF_FFFF);
      end else begin
        chk("wire_data", 32'(data_out), 32'(sb[0].d));
        chk("wire_pv", 32'(pkt_valid), 32'(sb[0].pv));
        if (pkt_valid && data_out == 8'h22) hold22++;
        if (!busy) begin
          void'(sb.pop_front());
          par_hold = 1'b0;
        end else begin
          par_hold = par;
        end
      end
    end
    last_pv = pkt_valid;
  endtask

  task automatic tick();
    mon();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [1:0] a, input logic [5:0] l, input bit toggle);
    logic [7:0] hdr, par;
    hdr = {l, a};
    par = hdr;
    sb.push_back('{d: hdr, pv: 1'b1});
    for (int i = 0; i < int'(l); i++) begin
      sb.push_back('{d: pay[i], pv: 1'b1});
      par = par ^ pay[i];
    end
    sb.push_back('{d: par, pv: 1'b0});
    start = 1'b1; dest_addr = a; pay_len = l;
    tick();
    start = 1'b0;
    chk("load_in_ready", 32'(in_ready), 32'd1);
    chk("load_idle_low", 32'(idle), 32'd0);
    for (int i = 0; i < int'(l); i++) begin
      if (toggle && i > 0) begin
        in_valid = 1'b0;
        tick();
        chk("gap_pv_low", 32'(pkt_valid), 32'd0);
      end
      in_data = pay[i];
      in_valid = 1'b1;
      chk("load_pv_low", 32'(pkt_valid), 32'd0);
      tick();
    end
    in_valid = 1'b0;
    chk("ready_drop", 32'(in_ready), 32'd0);
    chk("header_valid", 32'(pkt_valid), 32'd1);
  endtask

  task automatic wait_done(input logic exp_err);
    int n;
    n = 0;
    while (!tx_done && n < 300) begin
      tick();
      n++;
    end
    chk("done_seen", 32'(tx_done), 32'd1);
    chk("tx_err", 32'(tx_err), 32'(exp_err));
    chk("sb_empty", 32'(sb.size()), 32'd0);
    tick();
    chk("done_pulse", 32'(tx_done), 32'd0);
    chk("idle_after", 32'(idle), 32'd1);
  endtask

  task automatic set_pay3();
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
  endtask

  initial begin
    int n;
    @(negedge clk);
    tick();
    tick();
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_pv", 32'(pkt_valid), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);
    chk("rst_tx_done", 32'(tx_done), 32'd0);
    chk("rst_tx_err", 32'(tx_err), 32'd0);
    rst = 1'b1;
    tick();

    // Basic packet.
    set_pay3();
    send(2'd1, 6'd3, 1'b0);
    wait_done(1'b0);

    // Busy held four cycles on payload byte 0x22.
    hold22 = 0;
    send(2'd1, 6'd3, 1'b0);
    n = 0;
    while (!(pkt_valid && data_out == 8'h22) && n < 50) begin
      tick();
      n++;
    end
    chk("busy_target_seen", 32'(data_out), 32'h22);
    busy = 1'b1;
    repeat (4) tick();
    busy = 1'b0;
    wait_done(1'b0);
    chk("hold22_cycles", 32'(hold22), 32'd5);

    // Illegal configurations.
    start = 1'b1; dest_addr = 2'd3; pay_len = 6'd3;
    tick();
    start = 1'b0;
    chk("cfg_addr_pulse", 32'(cfg_err), 32'd1);
    chk("cfg_addr_idle", 32'(idle), 32'd1);
    tick();
    chk("cfg_addr_clear", 32'(cfg_err), 32'd0);
    chk("cfg_addr_ready", 32'(in_ready), 32'd0);
    start = 1'b1; dest_addr = 2'd0; pay_len = 6'd0;
    tick();
    start = 1'b0;
    chk("cfg_len_pulse", 32'(cfg_err), 32'd1);
    chk("cfg_len_idle", 32'(idle), 32'd1);
    tick();
    chk("cfg_len_clear", 32'(cfg_err), 32'd0);
    chk("cfg_pv_low", 32'(pkt_valid), 32'd0);

    // err in the third watch cycle, then a clean packet.
    send(2'd1, 6'd3, 1'b0);
    n = 0;
    while (pkt_valid && n < 50) begin
      tick();
      n++;
    end
    chk("parity_seen", 32'(pkt_valid), 32'd0);
    repeat (3) tick();
    err = 1'b1;
    tick();
    err = 1'b0;
    wait_done(1'b1);
    send(2'd1, 6'd3, 1'b0);
    wait_done(1'b0);

    // Toggling upstream valid; err outside the watch window is ignored.
    pay[0] = 8'hA5; pay[1] = 8'h3C; pay[2] = 8'h7E;
    err = 1'b1;
    send(2'd2, 6'd3, 1'b1);
    err = 1'b0;
    wait_done(1'b0);

    // Reset in the middle of a long payload.
    for (int i = 0; i < 10; i++) pay[i] = 8'(i * 7 + 1);
    send(2'd2, 6'd10, 1'b0);
    n = 0;
    while (!(pkt_valid && data_out == pay[1]) && n < 50) begin
      tick();
      n++;
    end
    chk("rst_target_seen", 32'(data_out), 32'(pay[1]));
    rst = 1'b0;
    tick();
    chk("abort_pv", 32'(pkt_valid), 32'd0);
    chk("abort_data", 32'(data_out), 32'd0);
    chk("abort_idle", 32'(idle), 32'd1);
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    sb.delete();
    last_pv = 1'b0;
    par_hold = 1'b0;
    tick();
    set_pay3();
    send(2'd1, 6'd3, 1'b0);
    wait_done(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
